nts_cookie_unwrap_sequencer: RTL
================================

# nts_cookie_unwrap_sequencer

Sequences `nts_cookie_handler` for cookie unwrap requests. It holds up to `KEYS` server master keys with their 32-bit key IDs and matches an incoming request's key ID against them. It streams the matching key into the handler's key port, pulses `i_op_unwrap`, waits for the handler to finish, and reports the tag result. It sits between the NTS parser, which supplies the key ID and streams cookie fields straight into the handler, and the handler itself. A one-entry cache skips the key reload when the same slot is used twice in a row.

## Interface
Parameters:
- `KEYS`, 4: number of key slots (power of two, 2..8).
- `BUSY_TIMEOUT`, 4: cycles allowed for handler busy to rise after the start pulse.

Ports (reset is synchronous and active-high):
- `i_clk` in 1: clock.
- `i_areset` in 1: synchronous active-high reset.
- `i_cfg_we` in 1: write one key word.
- `i_cfg_slot` in $clog2(KEYS): slot addressed by any cfg write.
- `i_cfg_word` in 4: key word index.
- `i_cfg_data` in 32: key word data.
- `i_cfg_id_we` in 1: write slot ID, length and valid fields.
- `i_cfg_id` in 32: key ID.
- `i_cfg_length` in 1: 1 = 512-bit key, 0 = 256-bit key.
- `i_cfg_valid` in 1: slot enable.
- `o_cfg_ready` out 1: cfg writes accepted; high only in IDLE.
- `i_req_valid` in 1: unwrap request.
- `i_req_keyid` in 32: key ID taken from the cookie.
- `o_req_ready` out 1: high only in IDLE.
- `o_done` out 1: one-cycle completion pulse.
- `o_key_found` out 1: valid with `o_done`.
- `o_tag_ok` out 1: valid with `o_done`.
- `o_timeout` out 1: valid with `o_done`.
- Handler side outputs: `o_key_word` out 4, `o_key_valid` out 1, `o_key_length` out 1, `o_key_data` out 32, `o_key_id` out 32, `o_op_unwrap` out 1.
- Handler side inputs: `i_busy` in 1, `i_unwrap_tag_ok` in 1.

## Operation
- **Reset.** All slot valid bits cleared, cache invalid, state IDLE. Every output is 0 except `o_cfg_ready` = 1 and `o_req_ready` = 1. Key data registers are not reset.
- **Config writes.** Accepted only when `o_cfg_ready` is high; otherwise silently dropped.
  - Any accepted write to the cached slot invalidates the cache.
- **States:**
  - IDLE: a request handshake (`i_req_valid` and `o_req_ready`) latches the key ID and moves to LOOKUP.
  - LOOKUP: compares the latched ID against all valid slots. On multiple matches the lowest index wins.
    - No match: go to DONE with `key_found` = 0.
    - Match equal to the valid cached slot: go to START.
    - Other match: go to LOAD.
  - LOAD: 16 cycles. `o_key_valid` = 1 and `o_key_word` counts 15 down to 0. `o_key_data` is that slot word, and `o_key_id` / `o_key_length` come from the slot. On exit the cache is set to this slot.
  - START: `o_op_unwrap` = 1 for one cycle, then WAIT_BUSY.
  - WAIT_BUSY: `i_busy` high moves to WAIT_DONE. If it stays low for `BUSY_TIMEOUT` cycles, go to DONE with timeout = 1, tag_ok = 0, and invalidate the cache.
  - WAIT_DONE: `i_busy` low samples `i_unwrap_tag_ok` into tag_ok, then DONE. There is no timeout in this state.
  - DONE: `o_done` = 1 with the result flags, then IDLE.
- Result flags hold their value until the next `o_done`.
- Reset in any state behaves as power-on reset, including mid-LOAD. `o_key_valid` and `o_op_unwrap` drop on the next edge.

## Timing
- Request accepted at edge 0.
- Cache miss: LOOKUP at cycle 1, LOAD at cycles 2–17, `o_op_unwrap` at cycle 18.
- Cache hit: `o_op_unwrap` at cycle 2.
- No match: `o_done` at cycle 2.
- `o_done` is asserted the cycle after `i_busy` is first seen low in WAIT_DONE.
- The earliest next request is accepted in the cycle after `o_done`.
- All outputs are registered. No combinational path from inputs to outputs except `o_cfg_ready` and `o_req_ready`, which decode the state register.

## Structure
- Shared package `nts_cookie_pkg` holds:
  - state encoding;
  - `KEY_WORDS` = 16;
  - `NTP_TAG_NTS_COOKIE` = 16'h0204;
  - cookie field word counts: nonce 4, c2s 8, s2c 8, tag 4.
- Sub-module `nts_key_store`: slot register file (words, ID, length, valid), write port, read port addressed by slot and word, and priority-encoded ID match outputs (`hit`, `hit_slot`).
- The FSM, timeout counter, word counter and cache register stay in the top module.

## Test plan
- Slot 1 loaded with ID 32'h6c47f0d3, key 3fc91575…16aeda8 (length 0); request that ID. Require exactly 16 `o_key_valid` cycles, words 15→0, data matching. `o_op_unwrap` at cycle 18. The handler model returns busy for 20 cycles with tag_ok = 1; require `o_done` with found = 1, tag_ok = 1, timeout = 0.
- Repeat the same request: no `o_key_valid` cycles, `o_op_unwrap` at cycle 2. Then write one word of slot 1 and repeat: the full reload occurs.
- Request ID 32'hdeadbeef with no matching slot: `o_done` at cycle 2, found = 0, `o_op_unwrap` never asserted.
- Slots 0 and 2 both hold ID 32'h1; request it: slot 0's data is streamed. Clear slot 0's valid bit and repeat: slot 2 is streamed.
- Handler model never raises busy: `o_done` after `BUSY_TIMEOUT` cycles with timeout = 1 and tag_ok = 0. The next request to the same ID fully reloads the key.
- Two cases:
  - Assert `i_areset` at LOAD word 7: all outputs reach reset values one cycle later and all slots read invalid.
  - Issue a cfg write while busy: it is dropped and the slot contents are unchanged.

Source files
------------

// File: rtl/nts_cookie_pkg.sv
// rtl/nts_cookie_pkg.sv - shared NTS cookie constants and sequencer state encoding
package nts_cookie_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_LOAD      = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_BUSY = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    localparam int          KEY_WORDS          = 16;
    localparam logic [3:0]  KEY_WORD_LAST      = 4'(KEY_WORDS - 1);
    localparam logic [15:0] NTP_TAG_NTS_COOKIE = 16'h0204;

    localparam int NONCE_WORDS = 4;
    localparam int C2S_WORDS   = 8;
    localparam int S2C_WORDS   = 8;
    localparam int TAG_WORDS   = 4;

endpackage

// File: rtl/nts_key_store.sv
// rtl/nts_key_store.sv - master key slot register file with priority key-ID match
module nts_key_store
    import nts_cookie_pkg::*;
#(
    parameter int KEYS = 4,
    parameter int SW   = $clog2(KEYS)
) (
    input  logic          i_clk,
    input  logic          i_areset,
    input  logic          i_we,
    input  logic [SW-1:0] i_wr_slot,
    input  logic [3:0]    i_wr_word,
    input  logic [31:0]   i_wr_data,
    input  logic          i_id_we,
    input  logic [31:0]   i_wr_id,
    input  logic          i_wr_length,
    input  logic          i_wr_valid,
    input  logic [SW-1:0] i_rd_slot,
    input  logic [3:0]    i_rd_word,
    output logic [31:0]   o_rd_data,
    output logic [31:0]   o_rd_id,
    output logic          o_rd_length,
    input  logic [31:0]   i_match_id,
    output logic          o_hit,
    output logic [SW-1:0] o_hit_slot
);

    logic [31:0]     r_words [KEYS][KEY_WORDS];
    logic [31:0]     r_ids   [KEYS];
    logic [KEYS-1:0] r_lens;
    logic [KEYS-1:0] r_valid;

    // Key material is deliberately left unreset; only the valid bits gate use.
    always_ff @(posedge i_clk) begin
        if (i_we)
            r_words[i_wr_slot][i_wr_word] <= i_wr_data;
        if (i_id_we) begin
            r_ids[i_wr_slot]  <= i_wr_id;
            r_lens[i_wr_slot] <= i_wr_length;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_areset)
            r_valid <= '0;
        else if (i_id_we)
            r_valid[i_wr_slot] <= i_wr_valid;
    end

    assign o_rd_data   = r_words[i_rd_slot][i_rd_word];
    assign o_rd_id     = r_ids[i_rd_slot];
    assign o_rd_length = r_lens[i_rd_slot];

    // Scan from the top so the lowest matching slot is the last to assign.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_slot = '0;
        for (int i = KEYS - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_ids[i] == i_match_id)) begin
                o_hit      = 1'b1;
                o_hit_slot = SW'(i);
            end
        end
    end

endmodule

// File: rtl/nts_cookie_unwrap_sequencer.sv
// rtl/nts_cookie_unwrap_sequencer.sv - key lookup, key streaming and unwrap sequencing for nts_cookie_handler
module nts_cookie_unwrap_sequencer
    import nts_cookie_pkg::*;
#(
    parameter int KEYS         = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                    i_clk,
    input  logic                    i_areset,
    input  logic                    i_cfg_we,
    input  logic [$clog2(KEYS)-1:0] i_cfg_slot,
    input  logic [3:0]              i_cfg_word,
    input  logic [31:0]             i_cfg_data,
    input  logic                    i_cfg_id_we,
    input  logic [31:0]             i_cfg_id,
    input  logic                    i_cfg_length,
    input  logic                    i_cfg_valid,
    output logic                    o_cfg_ready,
    input  logic                    i_req_valid,
    input  logic [31:0]             i_req_keyid,
    output logic                    o_req_ready,
    output logic                    o_done,
    output logic                    o_key_found,
    output logic                    o_tag_ok,
    output logic                    o_timeout,
    output logic [3:0]              o_key_word,
    output logic                    o_key_valid,
    output logic                    o_key_length,
    output logic [31:0]             o_key_data,
    output logic [31:0]             o_key_id,
    output logic                    o_op_unwrap,
    input  logic                    i_busy,
    input  logic                    i_unwrap_tag_ok
);

    localparam int SW = $clog2(KEYS);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    state_t        r_state;
    logic [31:0]   r_req_id;
    logic [SW-1:0] r_slot;
    logic [3:0]    r_word;
    logic          r_cache_valid;
    logic [SW-1:0] r_cache_slot;
    logic [TW-1:0] r_tmo_cnt;

    logic          w_idle;
    logic          w_cfg_hits_cache;
    logic          w_hit;
    logic [SW-1:0] w_hit_slot;
    logic [SW-1:0] w_rd_slot;
    logic [3:0]    w_rd_word;
    logic [31:0]   w_rd_data;
    logic [31:0]   w_rd_id;
    logic          w_rd_length;

    assign w_idle      = (r_state == ST_IDLE);
    assign o_cfg_ready = w_idle;
    assign o_req_ready = w_idle;

    assign w_cfg_hits_cache = w_idle && (i_cfg_we || i_cfg_id_we) && (i_cfg_slot == r_cache_slot);

    // Read address looks one word ahead so key outputs can be registered.
    assign w_rd_slot = (r_state == ST_LOOKUP) ? w_hit_slot : r_slot;
    assign w_rd_word = (r_state == ST_LOOKUP) ? KEY_WORD_LAST : (r_word - 4'd1);

    nts_key_store #(.KEYS(KEYS), .SW(SW)) u_key_store (
        .i_clk       (i_clk),
        .i_areset    (i_areset),
        .i_we        (i_cfg_we && w_idle),
        .i_wr_slot   (i_cfg_slot),
        .i_wr_word   (i_cfg_word),
        .i_wr_data   (i_cfg_data),
        .i_id_we     (i_cfg_id_we && w_idle),
        .i_wr_id     (i_cfg_id),
        .i_wr_length (i_cfg_length),
        .i_wr_valid  (i_cfg_valid),
        .i_rd_slot   (w_rd_slot),
        .i_rd_word   (w_rd_word),
        .o_rd_data   (w_rd_data),
        .o_rd_id     (w_rd_id),
        .o_rd_length (w_rd_length),
        .i_match_id  (r_req_id),
        .o_hit       (w_hit),
        .o_hit_slot  (w_hit_slot)
    );

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            r_state       <= ST_IDLE;
            r_req_id      <= '0;
            r_slot        <= '0;
            r_word        <= '0;
            r_cache_valid <= 1'b0;
            r_cache_slot  <= '0;
            r_tmo_cnt     <= '0;
            o_done        <= 1'b0;
            o_key_found   <= 1'b0;
            o_tag_ok      <= 1'b0;
            o_timeout     <= 1'b0;
            o_key_word    <= '0;
            o_key_valid   <= 1'b0;
            o_key_length  <= 1'b0;
            o_key_data    <= '0;
            o_key_id      <= '0;
            o_op_unwrap   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (w_cfg_hits_cache)
                r_cache_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_req_id <= i_req_keyid;
                        r_state  <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (!w_hit) begin
                        o_done      <= 1'b1;
                        o_key_found <= 1'b0;
                        o_tag_ok    <= 1'b0;
                        o_timeout   <= 1'b0;
                        r_state     <= ST_DONE;
                    end else if (r_cache_valid && (r_cache_slot == w_hit_slot)) begin
                        o_op_unwrap <= 1'b1;
                        r_state     <= ST_START;
                    end else begin
                        r_slot       <= w_hit_slot;
                        r_word       <= KEY_WORD_LAST;
                        o_key_valid  <= 1'b1;
                        o_key_word   <= KEY_WORD_LAST;
                        o_key_data   <= w_rd_data;
                        o_key_id     <= w_rd_id;
                        o_key_length <= w_rd_length;
                        r_state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (r_word == 4'd0) begin
                        o_key_valid   <= 1'b0;
                        o_op_unwrap   <= 1'b1;
                        r_cache_valid <= 1'b1;
                        r_cache_slot  <= r_slot;
                        r_state       <= ST_START;
                    end else begin
                        r_word     <= r_word - 4'd1;
                        o_key_word <= r_word - 4'd1;
                        o_key_data <= w_rd_data;
                    end
                end
                ST_START: begin
                    o_op_unwrap <= 1'b0;
                    r_tmo_cnt   <= '0;
                    r_state     <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (i_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_tmo_cnt == TW'(BUSY_TIMEOUT - 1)) begin
                        // The handler state is unknown after a missed start, so force a reload.
                        o_done        <= 1'b1;
                        o_key_found   <= 1'b1;
                        o_tag_ok      <= 1'b0;
                        o_timeout     <= 1'b1;
                        r_cache_valid <= 1'b0;
                        r_state       <= ST_DONE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!i_busy) begin
                        o_done      <= 1'b1;
                        o_key_found <= 1'b1;
                        o_tag_ok    <= i_unwrap_tag_ok;
                        o_timeout   <= 1'b0;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
